// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RISC-V decode stage with one-entry skid buffer and flush
// Optional DECODE_ILLEGAL_EN adds a registered out_illegal flag alongside the payload.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_bit20,
  output logic            out_bit30,
  output logic [XLEN-1:0] out_imm
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
`ifdef DECODE_ILLEGAL_EN
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            bit20;
    logic            bit30;
    logic [XLEN-1:0] imm;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } payload_t;

  payload_t   dec;
  logic [31:0] imm32;

  logic     m_valid_q, m_valid_d;
  logic     s_valid_q, s_valid_d;
  logic     in_ready_q, in_ready_d;
  payload_t m_q, m_d;
  payload_t s_q, s_d;

  logic accept;
  logic drain;

  // Every immediate format carries its sign in bit 31, so build 32 bits then sign-extend.
  always_comb begin
    imm32 = '0;
    case (in_inst[6:0])
      OP_STORE:          imm32 = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
      OP_JAL:            imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      OP_LUI, OP_AUIPC:  imm32 = {in_inst[31:12], 12'b0};
      OP_BRANCH:         imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      default:           imm32 = {{21{in_inst[31]}}, in_inst[30:20]};
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_inst[6:0];
    dec.rd     = in_inst[11:7];
    dec.rs1    = (in_inst[6:0] == OP_LUI) ? 5'd0 : in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.bit20  = in_inst[20];
    dec.bit30  = in_inst[30];
    dec.imm    = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = (in_inst[1:0] != 2'b11) ||
                  !(in_inst[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                         OP_STORE, OP_IMM, OP_OP, OP_MISC, OP_SYSTEM}) ||
                  ((in_inst[6:0] == OP_JALR) && (in_inst[14:12] != 3'b000));
`endif
  end

  assign accept = in_valid && in_ready_q;
  assign drain  = m_valid_q && out_ready;

  // in_ready is low whenever S is full, so an accept never coincides with a valid S.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = dec;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    m_q <= m_d;
    s_q <= s_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid_q;
  assign out_pc     = m_q.pc;
  assign out_opcode = m_q.opcode;
  assign out_rd     = m_q.rd;
  assign out_rs1    = m_q.rs1;
  assign out_rs2    = m_q.rs2;
  assign out_funct3 = m_q.funct3;
  assign out_funct7 = m_q.funct7;
  assign out_bit20  = m_q.bit20;
  assign out_bit30  = m_q.bit30;
  assign out_imm    = m_q.imm;
`ifdef DECODE_ILLEGAL_EN
  assign out_illegal = m_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage at XLEN 32 and 64
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        rdy_man = 1'b1;
  logic        rdy_rnd = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        out_ready;

  logic        in_ready, out_valid, out_bit20, out_bit30;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;

  logic        in_ready64, out_valid64, out_bit20_64, out_bit30_64;
  logic [63:0] in_pc64, out_pc64, out_imm64;
  logic [6:0]  out_opcode64, out_funct7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_funct3_64;
`ifdef DECODE_ILLEGAL_EN
  logic        out_illegal, out_illegal64;
`endif

  assign out_ready = rand_rdy ? rdy_rnd : rdy_man;
  assign in_pc64   = {32'h0, in_pc};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_bit20(out_bit20), .out_bit30(out_bit30), .out_imm(out_imm)
`ifdef DECODE_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs1_64),
    .out_rs2(out_rs2_64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
    .out_bit20(out_bit20_64), .out_bit30(out_bit30_64), .out_imm(out_imm64)
`ifdef DECODE_ILLEGAL_EN
    , .out_illegal(out_illegal64)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } sb_item_t;
  sb_item_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_imm(input logic [31:0] i);
    case (i[6:0])
      7'h23:        return {{52{i[31]}}, i[31:25], i[11:7]};
      7'h6f:        return {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      7'h37, 7'h17: return {{32{i[31]}}, i[31:12], 12'h000};
      7'h63:        return {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default:      return {{53{i[31]}}, i[30:20]};
    endcase
  endfunction

  function automatic logic [33:0] model_fld(input logic [31:0] i);
    logic [4:0] rs1;
    rs1 = (i[6:0] == 7'h37) ? 5'd0 : i[19:15];
    return {i[6:0], i[11:7], rs1, i[24:20], i[14:12], i[31:25], i[20], i[30]};
  endfunction

  function automatic logic model_illegal(input logic [31:0] i);
    logic known;
    known = i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    return (i[1:0] != 2'b11) || !known || (i[6:0] == 7'h67 && i[14:12] != 3'b000);
  endfunction

  // Monitor: pop before push, since what is on the outputs is older than what is being accepted.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("out_unexpected", out_valid, 0);
        end else begin
          sb_item_t e;
          e = sb.pop_front();
          n_pop++;
          check_eq("pc", out_pc, e.pc);
          check_eq("fields", {out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_bit20, out_bit30}, model_fld(e.inst));
          check_eq("imm", out_imm, {32'h0, model_imm(e.inst)[31:0]});
          check_eq("valid64", {out_valid64, in_ready64}, {out_valid, in_ready});
          check_eq("pc64", out_pc64, {32'h0, e.pc});
          check_eq("fields64", {out_opcode64, out_rd64, out_rs1_64, out_rs2_64, out_funct3_64, out_funct7_64, out_bit20_64, out_bit30_64}, model_fld(e.inst));
          check_eq("imm64", out_imm64, model_imm(e.inst));
`ifdef DECODE_ILLEGAL_EN
          check_eq("illegal", {out_illegal, out_illegal64}, {2{model_illegal(e.inst)}});
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back('{inst: in_inst, pc: in_pc});
    end
  end

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check_eq("send_accept", acc, 1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int pre;
    logic [31:0] r;
    logic [6:0]  ops [12];
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h2b};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);

    rdy_man = 1'b1;
    send(32'h00500093, 32'h100);
    in_valid = 1'b0;
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_rd", out_rd, 1);
    check_eq("t1_rs1", out_rs1, 0);
    check_eq("t1_imm", out_imm, 5);
    check_eq("t1_pc", out_pc, 32'h100);

    send(32'h123450B7, 32'h104);
    in_valid = 1'b0;
    check_eq("lui_imm", out_imm, 32'h12345000);
    check_eq("lui_rs1", out_rs1, 0);

    send(32'hFFF00093, 32'h108);
    in_valid = 1'b0;
    check_eq("neg_imm32", out_imm, 32'hFFFFFFFF);
    check_eq("neg_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);

    send(32'hFE20AE23, 32'h10C);
    in_valid = 1'b0;
    check_eq("sw_imm", out_imm, 32'hFFFFFFFC);
    check_eq("sw_regs", {out_rs1, out_rs2, out_funct3}, {5'd1, 5'd2, 3'd2});

    send(32'h00001067, 32'h110);
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    check_eq("ill_jalr", out_illegal, 1);
`endif
    send(32'h00000000, 32'h114);
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    check_eq("ill_zero", out_illegal, 1);
`endif
    send(32'h00500093, 32'h118);
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    check_eq("ill_addi", out_illegal, 0);
`endif
    idle(3);

    // Stall: A in M, B in S, C held off until release.
    pre = n_pop;
    send(32'h00100113, 32'h200);
    rdy_man = 1'b0;
    send(32'h00200193, 32'h204);
    in_inst = 32'h00300213;
    in_pc   = 32'h208;
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_m_pc", {out_valid, out_pc}, {1'b1, 32'h200});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("stall_hold", {in_ready, out_pc}, {1'b0, 32'h200});
    rdy_man = 1'b1;
    send(32'h00300213, 32'h208);
    send(32'h00400293, 32'h20C);
    idle(4);
    check_eq("stall_count", n_pop - pre, 4);

    // Flush with M and S full and an input presented.
    rdy_man = 1'b0;
    send(32'h00A00313, 32'h300);
    send(32'h00B00393, 32'h304);
    in_inst = 32'h00C00413;
    in_pc   = 32'h308;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("flush_drop_input", out_valid, 0);
    flush    = 1'b0;
    rdy_man  = 1'b1;
    idle(4);
    check_eq("flush_idle", out_valid, 0);

    // Mid-stream reset.
    rdy_man = 1'b0;
    send(32'h00D00493, 32'h400);
    send(32'h00E00513, 32'h404);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_eq("rst_mid", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    rdy_man = 1'b1;
    idle(2);

    // Random stream under random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      r = $urandom();
      send({r[31:7], ops[$urandom_range(0, 11)]}, 32'h1000 + 32'(k * 4));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    rdy_man  = 1'b1;
    idle(5);
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RISC-V instruction decode stage between fetch and execute. Splits a 32-bit instruction into register, function and immediate fields, sign-extending the immediate to a parametrised datapath width. A one-entry skid buffer gives full throughput with a registered `in_ready`. A synchronous flush discards in-flight instructions on redirect.

## Interface
- `XLEN`, 32: datapath width; only 32 and 64 are legal. Sets the width of `imm` and `pc`.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous discard of all held instructions.
- `in_valid` input 1: the upstream instruction is valid.
- `in_ready` output 1: the stage can accept an instruction; registered.
- `in_inst` input 32: raw instruction.
- `in_pc` input XLEN: instruction address, passed through.
- `out_valid` output 1: decoded fields are valid.
- `out_ready` input 1: downstream accepts.
- `out_pc` output XLEN: passed-through address.
- `out_opcode` output 7: `inst[6:0]`.
- `out_rd` output 5: `inst[11:7]`.
- `out_rs1` output 5: `inst[19:15]`, forced to 0 when the opcode is LUI.
- `out_rs2` output 5: `inst[24:20]`.
- `out_funct3` output 3: `inst[14:12]`.
- `out_funct7` output 7: `inst[31:25]`.
- `out_bit20` output 1: `inst[20]`.
- `out_bit30` output 1: `inst[30]`.
- `out_imm` output XLEN: decoded immediate.
- `out_illegal` output 1: present only with `DECODE_ILLEGAL_EN`.

## Operation
- Decode is combinational on the input and captured into a register. Outputs come only from registers; there is no combinational path from input to output.
- Immediate selection uses `s = inst[31]`. Each format is sign-extended with `s` to XLEN.
  - STORE `0100011` (S format): {s, inst[30:25], inst[11:7]}.
  - JAL `1101111` (J format): {s, inst[19:12], inst[20], inst[30:21], 0}.
  - LUI `0110111` and AUIPC `0010111` (U format): {inst[31:12], 12'b0}. Sign-extended above bit 31 when XLEN=64.
  - BRANCH `1100011` (B format): {s, inst[7], inst[30:25], inst[11:8], 0}.
  - All other opcodes (I format): {s, inst[30:20]}.
- Storage is two entries, main M and skid S. Each holds a valid bit and the decoded payload.
  - Outputs always show M.
  - `in_ready` is the registered value of `!S.valid`.
- Accept occurs when `in_valid && in_ready`. Drain occurs when `out_valid && out_ready`.
- Per-cycle update, when M is empty or M drains:
  - if S is valid, M takes S and S is cleared;
  - else if accepting, M takes the input;
  - else M is cleared.
- Per-cycle update, when M is held (valid and not draining):
  - if accepting, the input goes to S.
- Order is strictly FIFO. An instruction is never duplicated or dropped, except by flush or reset.
- `flush` takes priority over everything else.
  - Next cycle, `M.valid = S.valid = 0` and `in_ready = 1`.
  - An input presented in the flush cycle is discarded.
- Payload registers are not reset. Only the valid bits and `in_ready` reset.

## Timing
- Reset values: `out_valid = 0`, `in_ready = 1`. All other outputs are undefined until the first accept. Reset may arrive mid-stream and empties the stage.
- Latency is 1 cycle: an accept at edge N makes `out_valid` high after edge N.
- Throughput is 1 per cycle with `out_ready` held high.
- On a stall, one further instruction is absorbed into S. `in_ready` falls in the cycle after S fills.
- When `out_ready` returns, S moves to M. `in_ready` rises one cycle after S empties.
- An accept and a drain in the same cycle with S empty: M is replaced and `out_valid` stays high.

## Configuration
- With `DECODE_ILLEGAL_EN` defined, `out_illegal` is added and registered alongside the payload. It is 1 when any of the following holds:
  - `inst[1:0] != 2'b11`;
  - the opcode is outside {LUI, AUIPC, JAL, JALR `1100111`, BRANCH, LOAD `0000011`, STORE, OP-IMM `0010011`, OP `0110011`, MISC-MEM `0001111`, SYSTEM `1110011`};
  - the opcode is JALR and `funct3 != 0`.
- Illegal instructions still flow through the stage normally.
- Without the macro, the port and its logic are absent.

## Test plan
- Reset, then `0x00500093` at pc `0x100` -> one cycle later: `out_valid` = 1, rd = 1, rs1 = 0, imm = 5, pc = `0x100`.
- `0x123450B7` (LUI) -> imm = `0x12345000`, rs1 = 0 (the raw field is 8); with XLEN=64, `0xFFF00093` -> imm = `0xFFFFFFFFFFFFFFFF`.
- `0xFE20AE23` (sw x2,-4(x1)) -> imm = `0xFFFFFFFC`, rs1 = 1, rs2 = 2, funct3 = 2.
- Stream A, B, C, D back-to-back with `out_ready` = 0 from cycle 2:
  - A is held in M and B in S;
  - `in_ready` falls, so C waits;
  - on release, outputs appear in the order A, B, C, D with no gaps or duplicates.
- `flush` while M and S are both full and `in_valid` is high -> next cycle `out_valid` = 0 and `in_ready` = 1; the flushed instructions never appear.
- With `DECODE_ILLEGAL_EN`: `0x00001067` (JALR with funct3 = 1) -> illegal = 1; `0x00000000` -> illegal = 1; `0x00500093` -> illegal = 0.
